// File: rtl/mem_command_sequencer_if.sv
// Avalon-MM style master bus between the command sequencer and the SDRAM controller.
// The master modport is the sequencer side; the slave modport is the controller side.
interface mem_command_sequencer_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/mem_command_sequencer.sv
// Runs one clear/read/write memory command per rising edge of ioDone on an Avalon-MM master.
// state   | meaning
// IDLE    | memDone high, waiting for an ioDone rising edge
// WR_REQ  | single write of the latched address/data, held until accepted
// RD_REQ  | read request of the latched address, held until accepted
// RD_WAIT | waiting for readdatavalid, bounded by the read timeout
// CLR_REQ | back-to-back zero writes from address 0 up to CLEAR_LAST
module mem_command_sequencer #(
    parameter int                ADDR_W     = 25,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] CLEAR_LAST = {ADDR_W{1'b1}},
    parameter int                RD_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             modeInput,
    input  logic [ADDR_W-1:0]      memoryAddress,
    input  logic [DATA_W-1:0]      ioDataIn,
    input  logic                   ioDone,
    output logic                   memDone,
    output logic [DATA_W-1:0]      readData,
    output logic                   readValid,
    output logic                   memError,
    mem_command_sequencer_if.master avm
);
    localparam int               TMO_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, CLR_REQ} state_t;

    state_t            state_q, state_d;
    logic              io_done_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              rd_valid_q, rd_valid_d;
    logic              mem_error_q, mem_error_d;
    logic              start;

    assign start = ioDone & ~io_done_q;

    // io_done_q resets high so a level already high when reset releases is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            io_done_q   <= 1'b1;
            addr_q      <= '0;
            data_q      <= '0;
            clr_cnt_q   <= '0;
            tmo_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            io_done_q   <= ioDone;
            addr_q      <= addr_d;
            data_q      <= data_d;
            clr_cnt_q   <= clr_cnt_d;
            tmo_q       <= tmo_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            mem_error_q <= mem_error_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        data_d            = data_q;
        clr_cnt_d         = clr_cnt_q;
        tmo_d             = tmo_q;
        rd_data_d         = rd_data_q;
        rd_valid_d        = 1'b0;
        mem_error_d       = mem_error_q;
        avm.avm_address   = '0;
        avm.avm_read      = 1'b0;
        avm.avm_write     = 1'b0;
        avm.avm_writedata = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = memoryAddress;
                    data_d      = ioDataIn;
                    mem_error_d = 1'b0;
                    case (modeInput)
                        2'b10:   state_d = WR_REQ;
                        2'b01:   state_d = RD_REQ;
                        2'b00: begin
                            state_d   = CLR_REQ;
                            clr_cnt_d = '0;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WR_REQ: begin
                avm.avm_write     = 1'b1;
                avm.avm_address   = addr_q;
                avm.avm_writedata = data_q;
                if (!avm.avm_waitrequest) state_d = IDLE;
            end
            RD_REQ: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = addr_q;
                if (!avm.avm_waitrequest) begin
                    state_d = RD_WAIT;
                    tmo_d   = '0;
                end
            end
            RD_WAIT: begin
                // data arriving on the last allowed cycle still wins over the timeout
                if (avm.avm_readdatavalid) begin
                    rd_data_d  = avm.avm_readdata;
                    rd_valid_d = 1'b1;
                    state_d    = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    mem_error_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            CLR_REQ: begin
                avm.avm_write   = 1'b1;
                avm.avm_address = clr_cnt_q;
                if (!avm.avm_waitrequest) begin
                    if (clr_cnt_q == CLEAR_LAST) state_d = IDLE;
                    else clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign memDone   = (state_q == IDLE);
    assign readData  = rd_data_q;
    assign readValid = rd_valid_q;
    assign memError  = mem_error_q;
endmodule

// File: tb/tb_mem_command_sequencer.sv
// Bench for mem_command_sequencer: directed scenarios then random commands against a
// transaction-level model (expected bus writes/reads, busy length, read result, error flag).
module tb_mem_command_sequencer;
    localparam int              AW = 25;
    localparam int              DW = 16;
    localparam int              RT = 8;
    localparam logic [AW-1:0]   CL = 25'd3;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'b10;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          io_done = 1'b1;
    logic          mem_done, read_valid, mem_error;
    logic [DW-1:0] read_data;

    mem_command_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_command_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .CLEAR_LAST(CL), .RD_TIMEOUT(RT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .modeInput(mode), .memoryAddress(addr),
        .ioDataIn(wdata), .ioDone(io_done), .memDone(mem_done), .readData(read_data),
        .readValid(read_valid), .memError(mem_error), .avm(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // slave configuration, written only by the main sequence
    int            stall_n = 0;
    int            stall_at = -1;
    int            rd_lat = 0;
    logic [DW-1:0] rd_val = '0;
    int            cfg_gen = 0;

    // bus monitor results, written only by the monitor
    wr_t           wr_log[$];
    logic [AW-1:0] rd_log[$];
    int            rd_acc_total = 0, busy_total = 0, rv_total = 0, wr_hi_total = 0;
    int            both_total = 0, unstable_total = 0;

    // model state, written only by the main sequence
    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    logic [DW-1:0] exp_rdata = '0;
    logic          exp_err = 1'b0;
    int            wr_chk_i = 0, rd_chk_i = 0;

    // slave: stalls the first stall_n request cycles (optionally only at stall_at),
    // returns read data rd_lat cycles after acceptance (0 = never)
    initial begin : slave
        int seen_gen, stall_used, rd_cd, rd_seen;
        seen_gen = 0; stall_used = 0; rd_cd = 0; rd_seen = 0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        forever begin
            @(posedge clk); #1;
            if (cfg_gen != seen_gen) begin
                seen_gen   = cfg_gen;
                stall_used = 0;
            end
            bus.avm_readdatavalid = 1'b0;
            if (rd_cd == 1) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = rd_val;
                rd_cd = 0;
            end else if (rd_cd > 1) begin
                rd_cd--;
            end
            if (rd_acc_total != rd_seen) begin
                rd_seen = rd_acc_total;
                rd_cd   = rd_lat;
            end
            bus.avm_waitrequest = 1'b0;
            if ((bus.avm_write || bus.avm_read) && stall_used < stall_n &&
                (stall_at < 0 || int'(bus.avm_address) == stall_at)) begin
                bus.avm_waitrequest = 1'b1;
                stall_used++;
            end
        end
    end

    // monitor: samples mid-cycle what the DUT presents to the next rising edge
    initial begin : monitor
        logic                   prev_stall;
        logic [AW+DW+1:0]       prev_req;
        prev_stall = 1'b0;
        prev_req   = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!mem_done) busy_total++;
                if (read_valid) rv_total++;
                if (bus.avm_write) wr_hi_total++;
                if (bus.avm_write && bus.avm_read) both_total++;
                if (prev_stall && prev_req !== {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata})
                    unstable_total++;
                prev_stall = (bus.avm_write || bus.avm_read) && bus.avm_waitrequest;
                prev_req   = {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
                if (bus.avm_write && !bus.avm_waitrequest)
                    wr_log.push_back({bus.avm_address, bus.avm_writedata});
                if (bus.avm_read && !bus.avm_waitrequest) begin
                    rd_log.push_back(bus.avm_address);
                    rd_acc_total++;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!mem_done && n < budget) begin
            step();
            n++;
        end
        chk("idle_reached", mem_done, 1);
    endtask

    // returns one cycle after the DUT has sampled the rising edge; inputs are then scrambled
    task automatic start_cmd(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mode = m; addr = a; wdata = d; io_done = 1'b0;
        step();
        io_done = 1'b1;
        step();
        mode  = 2'($urandom);
        addr  = AW'($urandom);
        wdata = DW'($urandom);
    endtask

    task automatic chk_logs();
        chk("wr_count", wr_log.size(), exp_wr.size());
        for (int i = wr_chk_i; i < exp_wr.size() && i < wr_log.size(); i++) begin
            chk("wr_addr", wr_log[i].a, exp_wr[i].a);
            chk("wr_data", wr_log[i].d, exp_wr[i].d);
        end
        wr_chk_i = exp_wr.size();
        chk("rd_count", rd_log.size(), exp_rd.size());
        for (int i = rd_chk_i; i < exp_rd.size() && i < rd_log.size(); i++)
            chk("rd_addr", rd_log[i], exp_rd[i]);
        rd_chk_i = exp_rd.size();
    endtask

    task automatic push_clear(input int last);
        for (int i = 0; i <= last; i++) exp_wr.push_back({AW'(i), DW'(0)});
    endtask

    task automatic do_cmd(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int s, input int at, input int lat, input logic [DW-1:0] rv);
        int b0, r0, w0, exp_busy, exp_rv, exp_whi;
        stall_n = s; stall_at = at; rd_lat = lat; rd_val = rv; cfg_gen++;
        b0 = busy_total; r0 = rv_total; w0 = wr_hi_total;
        exp_busy = 0; exp_rv = 0; exp_whi = 0;
        case (m)
            2'b10: begin
                exp_wr.push_back({a, d});
                exp_busy = s + 1; exp_whi = s + 1; exp_err = 1'b0;
            end
            2'b01: begin
                exp_rd.push_back(a);
                if (lat >= 1 && lat < RT) begin
                    exp_rdata = rv; exp_err = 1'b0; exp_rv = 1; exp_busy = s + lat + 2;
                end else begin
                    exp_err = 1'b1; exp_busy = s + 1 + RT;
                end
            end
            2'b00: begin
                push_clear(int'(CL));
                exp_busy = int'(CL) + 1 + s; exp_whi = exp_busy; exp_err = 1'b0;
            end
            default: exp_err = 1'b0;
        endcase

        start_cmd(m, a, d);
        chk("err_cleared_on_start", mem_error, 0);
        case (m)
            2'b10: begin
                chk("wr_first_write", bus.avm_write, 1);
                chk("wr_first_addr", bus.avm_address, a);
                chk("wr_first_data", bus.avm_writedata, d);
            end
            2'b01: begin
                chk("rd_first_read", bus.avm_read, 1);
                chk("rd_first_nowrite", bus.avm_write, 0);
                chk("rd_first_addr", bus.avm_address, a);
            end
            2'b00: begin
                chk("clr_first_addr", bus.avm_address, 0);
                chk("clr_first_data", bus.avm_writedata, 0);
            end
            default: chk("noop_done", mem_done, 1);
        endcase
        wait_idle(4 * RT + 64);
        step(2);
        chk("busy_cycles", busy_total - b0, exp_busy);
        chk("write_cycles", wr_hi_total - w0, exp_whi);
        chk("readvalid_pulses", rv_total - r0, exp_rv);
        chk("read_data", read_data, exp_rdata);
        chk("mem_error", mem_error, exp_err);
        chk_logs();
    endtask

    initial begin : main
        int b0, n;

        // ioDone high through reset with a write code presented
        step(2);
        chk("rst_mem_done", mem_done, 1);
        chk("rst_read_data", read_data, 0);
        chk("rst_read_valid", read_valid, 0);
        chk("rst_mem_error", mem_error, 0);
        chk("rst_avm_read", bus.avm_read, 0);
        chk("rst_avm_write", bus.avm_write, 0);
        chk("rst_avm_address", bus.avm_address, 0);
        chk("rst_avm_writedata", bus.avm_writedata, 0);
        rst_n = 1'b1;
        step(6);
        chk("held_iodone_no_cmd_busy", busy_total, 0);
        chk("held_iodone_no_cmd_writes", wr_log.size(), 0);

        // directed: write with 3 stalls, read with latency 2, timeout, error clearing
        do_cmd(2'b10, 25'h0001234, 16'hBEEF, 3, -1, 0, '0);
        do_cmd(2'b01, 25'h1000010, 16'h0000, 0, -1, 2, 16'hA5A5);
        do_cmd(2'b01, 25'h0000777, 16'h0000, 1, -1, 0, 16'h1111);
        do_cmd(2'b10, 25'h0000042, 16'h1357, 0, -1, 0, '0);
        do_cmd(2'b01, 25'h0000100, 16'h0000, 0, -1, 0, 16'h2222);
        do_cmd(2'b11, 25'h0000100, 16'h0000, 0, -1, 0, '0);
        // last allowed cycle vs one cycle too late (late data must be ignored)
        do_cmd(2'b01, 25'h0000200, 16'h0000, 2, -1, RT - 1, 16'h5AA5);
        do_cmd(2'b01, 25'h0000201, 16'h0000, 0, -1, RT, 16'hDEAD);
        // clear with a stall on address 2
        do_cmd(2'b00, 25'h0000000, 16'h0000, 1, 2, 0, '0);

        // ioDone edge during an active clear is dropped
        stall_n = 2; stall_at = 1; rd_lat = 0; cfg_gen++;
        b0 = busy_total;
        start_cmd(2'b00, '0, '0);
        step();
        io_done = 1'b0; mode = 2'b10; addr = 25'h0000ABC; wdata = 16'hCAFE;
        step();
        io_done = 1'b1;
        step();
        wait_idle(64);
        step(4);
        push_clear(int'(CL));
        chk("toggle_busy_cycles", busy_total - b0, int'(CL) + 1 + 2);
        chk_logs();

        // reset in the middle of a clear, while address 2 is stalled
        stall_n = 6; stall_at = 2; cfg_gen++;
        start_cmd(2'b00, '0, '0);
        n = 0;
        while (bus.avm_address != 2 && n < 20) begin
            step();
            n++;
        end
        chk("clr_reached_addr2", bus.avm_address, 2);
        rst_n = 1'b0;
        #1;
        chk("midclr_rst_write_low", bus.avm_write, 0);
        chk("midclr_rst_done", mem_done, 1);
        chk("midclr_rst_addr", bus.avm_address, 0);
        push_clear(1);
        exp_rdata = '0; exp_err = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("midclr_read_data_reset", read_data, 0);
        chk_logs();
        do_cmd(2'b00, 25'h0000000, 16'h0000, 0, -1, 0, '0);

        // random commands
        for (int k = 0; k < 24; k++) begin
            do_cmd(2'($urandom_range(0, 3)), AW'($urandom), DW'($urandom),
                   int'($urandom_range(0, 3)), -1, int'($urandom_range(0, RT)), DW'($urandom));
        end

        chk("never_read_and_write", both_total, 0);
        chk("stalled_request_stable", unstable_total, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
